// File: rtl/mem_stage_ls_pkg.sv
// ==== mem_stage_ls_pkg : opcodes, FSM states, stall levels and bus layout for the MEM stage | rev 1.0 ====
`default_nettype none

package mem_stage_ls_pkg;

  localparam int EXM_W   = 82;
  localparam int MEMWB_W = 70;
  localparam int RF_W    = 38;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic [5:0]  ld_st_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } exm_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_load(input exm_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000) && is_load_op(b.ld_st_op);
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ==== mem_load_align : little-endian lane select with sign/zero extension | rev 1.0 ====
`default_nettype none

module mem_load_align
  import mem_stage_ls_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [5:0]  ld_st_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_st_op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ls.sv
// ==== mem_stage_ls : MEM stage with load family and variable-latency SRAM handshake | rev 1.0 ====
// ==== optional: MEM_UNALIGNED_EXC_EN adds mem_adel / mem_ades misalignment flags     ====
`default_nettype none

module mem_stage_ls
  import mem_stage_ls_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int EXM_W     = mem_stage_ls_pkg::EXM_W,
  parameter int MEMWB_W   = mem_stage_ls_pkg::MEMWB_W,
  parameter int RF_W      = mem_stage_ls_pkg::RF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [EXM_W-1:0]   ex_to_mem_bus,
  input  logic [31:0]        data_sram_rdata,
  input  logic               data_sram_rvalid,
  output logic               stallreq_mem,
  output logic [MEMWB_W-1:0] mem_to_wb_bus,
  output logic [RF_W-1:0]    mem_to_rf_bus
`ifdef MEM_UNALIGNED_EXC_EN
  ,
  output logic               mem_adel,
  output logic               mem_ades
`endif
);

  exm_t        ex_in;
  exm_t        stage_q;
  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] buf_q;
  logic [31:0] ld_src;
  logic [31:0] ld_data;
  logic [31:0] wdata;
  logic        we;
  logic        busy;
  logic        own_stop;
  logic        down_stop;
  logic        capture;
  logic        bubble;
  logic        in_load;
  logic        adel;
  logic        unused_stall;

  assign ex_in        = ex_to_mem_bus;
  assign own_stop     = (stall[STAGE_IDX] == STOP);
  assign down_stop    = (stall[STAGE_IDX+1] == STOP);
  assign unused_stall = ^stall;

  // A load still waiting on its response (or a dropped one) owns the register.
  assign busy    = ((state_q == ST_WAIT) && !data_sram_rvalid) || (state_q == ST_DROP);
  assign capture = !flush && !busy && !own_stop;
  assign bubble  = !flush && !busy && own_stop && !down_stop;

`ifdef MEM_UNALIGNED_EXC_EN
  assign in_load  = is_load(ex_in) && !misaligned(ex_in.ld_st_op, ex_in.ex_result[1:0]);
  assign adel     = is_load(stage_q) && misaligned(stage_q.ld_st_op, stage_q.ex_result[1:0]);
  assign mem_adel = adel;
  assign mem_ades = stage_q.data_ram_en && is_store_op(stage_q.ld_st_op)
                    && misaligned(stage_q.ld_st_op, stage_q.ex_result[1:0]);
`else
  assign in_load = is_load(ex_in);
  assign adel    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (bubble) begin
      stage_q <= '0;
    end else if (capture) begin
      stage_q <= ex_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if ((state_q == ST_WAIT) && data_sram_rvalid) begin
      buf_q <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_DROP) begin
      if (data_sram_rvalid) state_d = ST_IDLE;
    end else if (flush) begin
      // A flushed read still has a response in flight unless it lands this cycle.
      state_d = ((state_q == ST_WAIT) && !data_sram_rvalid) ? ST_DROP : ST_IDLE;
    end else if (capture) begin
      state_d = in_load ? ST_WAIT : ST_IDLE;
    end else if (bubble) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_WAIT) && data_sram_rvalid) begin
      state_d = ST_DONE;
    end
  end

  mem_load_align u_align (
    .rdata    (ld_src),
    .off      (stage_q.ex_result[1:0]),
    .ld_st_op (stage_q.ld_st_op),
    .data     (ld_data)
  );

  always_comb begin
    stallreq_mem  = busy;
    ld_src        = data_sram_rvalid ? data_sram_rdata : buf_q;
    wdata         = stage_q.sel_rf_res ? ld_data : stage_q.ex_result;
    we            = stage_q.rf_we && !busy && !adel;
    mem_to_wb_bus = {stage_q.pc, we, stage_q.rf_waddr, wdata};
    mem_to_rf_bus = {we, stage_q.rf_waddr, wdata};
  end

endmodule

`default_nettype wire
